// File: rtl/addsub_accum_pkg.sv
// Shared definitions for the add/subtract accumulator: the frame state
// encoding and the saturation limits. The limits are built from a width by
// helper functions, so each instance can size them to its own WIDTH.
// The saturation limits are used only when ADDSUB_SAT_EN is defined.
package addsub_accum_pkg;

  // Frame states: IDLE (empty accumulator), ACCUM (frame in progress),
  // HOLD (result presented, waiting for the consumer).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Width of the standard datapath instance.
  localparam int ADDSUB_WIDTH = 4;

  // Largest positive two's-complement value of a w-bit word (0111...).
  function automatic logic [31:0] sat_max_f(input int w);
    sat_max_f = (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Most negative two's-complement value of a w-bit word (1000...).
  function automatic logic [31:0] sat_min_f(input int w);
    sat_min_f = 32'd1 << (w - 1);
  endfunction

  // Saturation limits for the standard datapath width.
  localparam logic [ADDSUB_WIDTH-1:0] SAT_MAX = ADDSUB_WIDTH'(sat_max_f(ADDSUB_WIDTH));
  localparam logic [ADDSUB_WIDTH-1:0] SAT_MIN = ADDSUB_WIDTH'(sat_min_f(ADDSUB_WIDTH));

endpackage

// File: rtl/addsub_accum_core.sv
// Combinational WIDTH-bit ripple-carry add/subtract core.
// Subtraction is a + ~b + 1: b is inverted and carry-in equals sub, so
// cout = 1 on subtract means "no borrow". Signed overflow is flagged when
// both effective operands share a sign and the sum's sign differs.
module addsub_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   carry;

  // Ripple the carry bit by bit through the effective operands.
  always_comb begin
    b_eff    = b ^ {WIDTH{sub}};
    carry    = '0;
    carry[0] = sub;
    sum      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
    cout = carry[WIDTH];
    ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/addsub_accum.sv
// Frame accumulator around addsub_core. Operands stream in, each one is
// added to or subtracted from the running accumulator; after NUM_OPS
// operands or an operand flagged last, the result with carry, sticky
// overflow and operand count is held on the output until taken.
// Optional feature: define ADDSUB_SAT_EN to clamp the accumulator to the
// signed limits on overflow instead of wrapping.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready depends only on state; in_valid may wait on it. out_valid rises
// with the final operand and stays high, with all result outputs frozen,
// until an edge with out_ready = 1 releases it.
module addsub_accum
  import addsub_accum_pkg::*;
#(
  parameter int WIDTH   = ADDSUB_WIDTH,
  parameter int NUM_OPS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_sub,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_acc,
  output logic                           out_cout,
  output logic                           out_ovf,
  output logic [$clog2(NUM_OPS+1)-1:0]   out_count
);

  localparam int CW = $clog2(NUM_OPS + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] core_sum;
  logic             core_cout;
  logic             core_ovf;
  logic [WIDTH-1:0] acc_upd;
  logic [CW-1:0]    count_inc;
  logic             accept;
  logic             final_op;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a    (acc_q),
    .b    (in_data),
    .sub  (in_sub),
    .sum  (core_sum),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX_W = WIDTH'(sat_max_f(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN_W = WIDTH'(sat_min_f(WIDTH));

  // On overflow both effective operands share the accumulator's sign, which
  // is the sign of the true result, so clamp toward that side.
  always_comb begin
    acc_upd = core_sum;
    if (core_ovf) begin
      acc_upd = acc_q[WIDTH-1] ? SAT_MIN_W : SAT_MAX_W;
    end
  end
`else
  // Wrap mode: the core sum is taken modulo 2^WIDTH as is.
  always_comb begin
    acc_upd = core_sum;
  end
`endif

  // Next-state and datapath update for accept and release.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    count_inc = count_q + CW'(1);
    accept    = in_valid && (state_q != ST_HOLD);
    final_op  = in_last || (count_inc == CW'(NUM_OPS));
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          acc_d   = acc_upd;
          cout_d  = core_cout;
          ovf_d   = ovf_q | core_ovf;
          count_d = count_inc;
          state_d = final_op ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign out_acc   = acc_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;

endmodule
